// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the regfile write port between the ALU (A) and load (B) writeback requesters.
// One accept per cycle, issued a cycle later; writes to the zero register are counted and swallowed.
module regfile_write_arbiter #(
   parameter int AW        = 5,
   parameter int DW        = 64,
   parameter int XZR_IDX   = 31,
   parameter int PRIO_MODE = 0
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   output logic          we3,
   output logic [AW-1:0] wa3,
   output logic [DW-1:0] wd3,
   output logic          last_grant,
   output logic [7:0]    xzr_drops
);
   localparam logic [AW-1:0] XZR = AW'(XZR_IDX);
   logic          grant_a, grant_b, accept, drop;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   // In round-robin mode A wins a contended cycle only if B took the previous grant.
   always_comb begin
      grant_a = a_valid && (!b_valid || PRIO_MODE != 0 || last_grant);
      grant_b = b_valid && !grant_a;
      accept  = grant_a || grant_b;
      addr    = grant_a ? a_addr : b_addr;
      data    = grant_a ? a_data : b_data;
      drop    = accept && addr == XZR;
   end
   assign a_ready = grant_a;
   assign b_ready = grant_b;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we3        <= 1'b0;
         wa3        <= '0;
         wd3        <= '0;
         last_grant <= 1'b1;
         xzr_drops  <= 8'd0;
      end else begin
         we3 <= accept && !drop;
         if (accept && !drop) begin
            wa3 <= addr;
            wd3 <= data;
         end
         if (accept) last_grant <= grant_b;
         if (drop && xzr_drops != 8'hff) xzr_drops <= xzr_drops + 8'd1;
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: round-robin (inst 0) and fixed-priority (inst 1) arbiters checked
// cycle by cycle against a behavioural model, plus directed literal scenarios.
module tb_regfile_write_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        av [2], bv [2], ar [2], br [2];
   logic [4:0]  aa [2], ba [2];
   logic [63:0] ad [2], bd [2];
   logic        we3 [2], lgo [2];
   logic [4:0]  wa3 [2];
   logic [63:0] wd3 [2];
   logic [7:0]  drops_o [2];

   int          errors = 0, checks = 0;
   int          lg [2], drops [2];
   bit          ewe [2], wk [2], acc_a [2], acc_b [2];
   logic [4:0]  ewa [2];
   logic [63:0] ewd [2];
   logic [63:0] rf_exp [2][32], rf_dut [2][32];

   always #5 clk = ~clk;

   regfile_write_arbiter #(.PRIO_MODE(0)) dut_rr (
      .clk(clk), .reset(reset),
      .a_valid(av[0]), .a_ready(ar[0]), .a_addr(aa[0]), .a_data(ad[0]),
      .b_valid(bv[0]), .b_ready(br[0]), .b_addr(ba[0]), .b_data(bd[0]),
      .we3(we3[0]), .wa3(wa3[0]), .wd3(wd3[0]), .last_grant(lgo[0]), .xzr_drops(drops_o[0]));

   regfile_write_arbiter #(.PRIO_MODE(1)) dut_fp (
      .clk(clk), .reset(reset),
      .a_valid(av[1]), .a_ready(ar[1]), .a_addr(aa[1]), .a_data(ad[1]),
      .b_valid(bv[1]), .b_ready(br[1]), .b_addr(ba[1]), .b_data(bd[1]),
      .we3(we3[1]), .wa3(wa3[1]), .wd3(wd3[1]), .last_grant(lgo[1]), .xzr_drops(drops_o[1]));

   // The regfile as seen through the DUT's write port.
   always @(posedge clk)
      for (int m = 0; m < 2; m++)
         if (we3[m]) rf_dut[m][wa3[m]] <= wd3[m];

   task automatic chk(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, m, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         lg[m] = 1; drops[m] = 0; ewe[m] = 0; wk[m] = 1; ewa[m] = '0; ewd[m] = '0;
      end
   endtask

   // Called after inputs are set for this cycle; returns at posedge+1 with outputs checked.
   task automatic step();
      #1;
      for (int m = 0; m < 2; m++) begin
         int win;
         logic [4:0] addr;
         logic [63:0] data;
         win = -1;
         if (av[m] && bv[m]) win = (m == 1) ? 0 : 1 - lg[m];
         else if (av[m]) win = 0;
         else if (bv[m]) win = 1;
         acc_a[m] = (win == 0);
         acc_b[m] = (win == 1);
         chk("a_ready", m, 64'(ar[m]), 64'(acc_a[m]));
         chk("b_ready", m, 64'(br[m]), 64'(acc_b[m]));
         ewe[m] = 0;
         if (win >= 0) begin
            addr = win == 0 ? aa[m] : ba[m];
            data = win == 0 ? ad[m] : bd[m];
            lg[m] = win;
            if (addr == 5'd31) begin
               drops[m] = drops[m] == 255 ? 255 : drops[m] + 1;
               wk[m] = 0;
            end else begin
               ewe[m] = 1; ewa[m] = addr; ewd[m] = data; wk[m] = 1;
               rf_exp[m][addr] = data;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         chk("we3", m, 64'(we3[m]), 64'(ewe[m]));
         if (wk[m]) begin
            chk("wa3", m, 64'(wa3[m]), 64'(ewa[m]));
            chk("wd3", m, wd3[m], ewd[m]);
         end
         chk("last_grant", m, 64'(lgo[m]), 64'(lg[m]));
         chk("xzr_drops", m, 64'(drops_o[m]), 64'(drops[m]));
      end
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         av[m] = 0; bv[m] = 0; aa[m] = '0; ba[m] = '0; ad[m] = '0; bd[m] = '0;
         for (int r = 0; r < 32; r++) begin rf_exp[m][r] = '0; rf_dut[m][r] = '0; end
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 0;
      for (int m = 0; m < 2; m++) begin
         chk("rst we3", m, 64'(we3[m]), 64'd0);
         chk("rst wa3", m, 64'(wa3[m]), 64'd0);
         chk("rst wd3", m, wd3[m], 64'd0);
         chk("rst last_grant", m, 64'(lgo[m]), 64'd1);
         chk("rst xzr_drops", m, 64'(drops_o[m]), 64'd0);
      end

      // Single XZR write from B is accepted but not issued.
      bv[0] = 1; ba[0] = 31; bd[0] = 23;
      step();
      chk("xzr b_ready", 0, 64'(acc_b[0]), 64'd1);
      chk("xzr we3", 0, 64'(we3[0]), 64'd0);
      chk("xzr drops1", 0, 64'(drops_o[0]), 64'd1);
      bv[0] = 0;

      // Single writer: one-cycle latency, one-cycle pulse.
      av[0] = 1; aa[0] = 23; ad[0] = 46;
      step();
      chk("single a_ready", 0, 64'(acc_a[0]), 64'd1);
      chk("single we3", 0, 64'(we3[0]), 64'd1);
      chk("single wa3", 0, 64'(wa3[0]), 64'd23);
      chk("single wd3", 0, wd3[0], 64'd46);
      av[0] = 0;
      step();
      chk("single we3 off", 0, 64'(we3[0]), 64'd0);

      // Reset with a write in flight.
      aa[0] = 5; ad[0] = 46; av[0] = 1;
      #1 chk("midflight a_ready", 0, 64'(ar[0]), 64'd1);
      reset = 1;
      #1;
      chk("midflight we3", 0, 64'(we3[0]), 64'd0);
      chk("midflight last_grant", 0, 64'(lgo[0]), 64'd1);
      chk("midflight drops", 0, 64'(drops_o[0]), 64'd0);
      model_reset();
      @(posedge clk);
      #1 av[0] = 0; reset = 0;
      #1 chk("midflight post we3", 0, 64'(we3[0]), 64'd0);
      chk("midflight reg5", 0, rf_dut[0][5], 64'd0);

      // Saturation after 300 XZR writes.
      bv[0] = 1; ba[0] = 31; bd[0] = 23;
      repeat (300) step();
      chk("xzr saturate", 0, 64'(drops_o[0]), 64'd255);
      bv[0] = 0;

      // Round-robin contention: last grant was B, so A,B,A,B.
      av[0] = 1; aa[0] = 1; ad[0] = 10; bv[0] = 1; ba[0] = 2; bd[0] = 20;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr a_ready", 0, 64'(acc_a[0]), 64'(i % 2 == 0));
         chk("rr b_ready", 0, 64'(acc_b[0]), 64'(i % 2 == 1));
      end
      av[0] = 0; bv[0] = 0;

      // Fixed priority: A always wins, B gets in once A drops.
      av[1] = 1; aa[1] = 1; ad[1] = 10; bv[1] = 1; ba[1] = 2; bd[1] = 20;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fp a_ready", 1, 64'(acc_a[1]), 64'd1);
         chk("fp b_ready", 1, 64'(acc_b[1]), 64'd0);
      end
      av[1] = 0;
      step();
      chk("fp b after a", 1, 64'(acc_b[1]), 64'd1);
      bv[1] = 0;

      // Back-to-back writes, no bubbles.
      for (int i = 0; i < 3; i++) begin
         av[0] = 1; aa[0] = 5'(3 + i); ad[0] = 64'(7 + i);
         step();
         chk("b2b we3", 0, 64'(we3[0]), 64'd1);
      end
      av[0] = 0;
      step();
      chk("b2b reg3", 0, rf_dut[0][3], 64'd7);
      chk("b2b reg4", 0, rf_dut[0][4], 64'd8);
      chk("b2b reg5", 0, rf_dut[0][5], 64'd9);

      // Random traffic on both instances, requests held until accepted.
      for (int n = 0; n < 2000; n++) begin
         for (int m = 0; m < 2; m++) begin
            if (!av[m] || acc_a[m]) begin
               av[m] = ($urandom % 3) != 0;
               aa[m] = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom % 32);
               ad[m] = {$urandom, $urandom};
            end
            if (!bv[m] || acc_b[m]) begin
               bv[m] = ($urandom % 3) != 0;
               ba[m] = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom % 32);
               bd[m] = {$urandom, $urandom};
            end
         end
         step();
      end
      for (int m = 0; m < 2; m++) begin
         av[m] = 0; bv[m] = 0;
      end
      step();
      for (int m = 0; m < 2; m++)
         for (int r = 0; r < 32; r++)
            chk("regfile", m, rf_dut[m][r], rf_exp[m][r]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
